// File: rtl/wr_rotate_pack.sv
// wr_rotate_pack: packs 32-bit pixels into 256-bit DDR words, queues them and issues write bursts
module wr_rotate_pack #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 256,
    parameter int FIFO_AW    = 4,
    parameter int BURST_LEN  = 8,
    parameter int ADDR_WIDTH = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [ADDR_WIDTH-1:0]   frame_base,
    input  logic [IN_WIDTH-1:0]     pix_data,
    input  logic                    pix_valid,
    input  logic                    pix_last,
    output logic                    pix_ready,
    output logic                    burst_req,
    output logic [ADDR_WIDTH-1:0]   burst_addr,
    output logic [FIFO_AW:0]        burst_len,
    input  logic                    burst_ack,
    output logic [OUT_WIDTH-1:0]    ddr_wr_data,
    output logic [OUT_WIDTH/8-1:0]  ddr_wr_be,
    output logic                    ddr_wr_valid,
    output logic                    ddr_wr_last,
    input  logic                    ddr_wr_ready,
    output logic                    busy
);
    localparam int LANES = OUT_WIDTH / IN_WIDTH;
    localparam int LW    = $clog2(LANES);
    localparam int BW    = OUT_WIDTH / 8;
    localparam int LBW   = IN_WIDTH / 8;
    localparam logic [FIFO_AW:0] BL = (FIFO_AW+1)'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t                 state;
    logic [LW-1:0]          lane;
    logic [OUT_WIDTH-1:0]   acc_data, word_data;
    logic [BW-1:0]          acc_be, word_be;
    logic [OUT_WIDTH-1:0]   mem_data [2**FIFO_AW];
    logic [BW-1:0]          mem_be   [2**FIFO_AW];
    logic [FIFO_AW-1:0]     wp, rp;
    logic [FIFO_AW:0]       cnt, beat_cnt;
    logic                   flush_pending;
    logic                   accept, push, pop, fs_ok, start_full, start_flush, go;

    // the FIFO is full exactly when the count reaches 2^FIFO_AW, i.e. its top bit
    assign pix_ready    = !cnt[FIFO_AW] && !frame_start;
    assign accept       = pix_valid && pix_ready;
    assign push         = accept && (lane == LW'(LANES-1) || pix_last);
    assign busy         = (cnt != '0) || (state != IDLE) || (lane != '0);
    assign fs_ok        = frame_start && !busy;
    assign word_data    = acc_data | (OUT_WIDTH'(pix_data) << (lane * IN_WIDTH));
    assign word_be      = acc_be | (BW'({LBW{1'b1}}) << (lane * LBW));
    assign ddr_wr_valid = (state == DATA) && (cnt != '0);
    assign ddr_wr_last  = ddr_wr_valid && (beat_cnt == (FIFO_AW+1)'(1));
    assign ddr_wr_data  = ddr_wr_valid ? mem_data[rp] : '0;
    assign ddr_wr_be    = ddr_wr_valid ? mem_be[rp] : '0;
    assign pop          = ddr_wr_valid && ddr_wr_ready;
    assign start_full   = cnt >= BL;
    assign start_flush  = flush_pending && (cnt != '0);
    assign go           = (state == IDLE) && (start_full || start_flush);

    // packer: accumulate pixels lane by lane, unfilled lanes stay zero on a line-end push
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            lane     <= '0;
            acc_data <= '0;
            acc_be   <= '0;
        end else if (fs_ok) begin
            lane     <= '0;
            acc_data <= '0;
            acc_be   <= '0;
        end else if (accept) begin
            lane     <= push ? '0 : lane + 1'b1;
            acc_data <= push ? '0 : word_data;
            acc_be   <= push ? '0 : word_be;
        end

    // FIFO storage: data and byte enables travel together
    always_ff @(posedge clk)
        if (push) begin
            mem_data[wp] <= word_data;
            mem_be[wp]   <= word_be;
        end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end

    // burst FSM: request, then stream burst_len beats from the FIFO head
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            burst_req     <= 1'b0;
            burst_addr    <= '0;
            burst_len     <= '0;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
        end else begin
            // a burst that takes every queued word also carries any pending line end
            if (push && pix_last) flush_pending <= 1'b1;
            else if (go && cnt <= BL) flush_pending <= 1'b0;
            if (fs_ok) burst_addr <= frame_base;
            case (state)
                IDLE: if (go) begin
                    state     <= REQ;
                    burst_req <= 1'b1;
                    burst_len <= start_full ? BL : cnt;
                end
                REQ: if (burst_ack) begin
                    state     <= DATA;
                    burst_req <= 1'b0;
                    beat_cnt  <= burst_len;
                end
                DATA: if (pop) begin
                    beat_cnt <= beat_cnt - 1'b1;
                    if (beat_cnt == (FIFO_AW+1)'(1)) begin
                        burst_addr <= burst_addr + ADDR_WIDTH'(burst_len);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_wr_rotate_pack.sv
// tb_wr_rotate_pack: scoreboard bench for the pixel packer / DDR write burst block
module tb_wr_rotate_pack;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         frame_start = 0;
    logic [27:0]  frame_base = '0;
    logic [31:0]  pix_data = '0;
    logic         pix_valid = 0;
    logic         pix_last = 0;
    logic         pix_ready;
    logic         burst_req;
    logic [27:0]  burst_addr;
    logic [4:0]   burst_len;
    logic         burst_ack = 0;
    logic [255:0] ddr_wr_data;
    logic [31:0]  ddr_wr_be;
    logic         ddr_wr_valid;
    logic         ddr_wr_last;
    logic         ddr_wr_ready = 0;
    logic         busy;

    wr_rotate_pack dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_base(frame_base),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
        .burst_req(burst_req), .burst_addr(burst_addr), .burst_len(burst_len), .burst_ack(burst_ack),
        .ddr_wr_data(ddr_wr_data), .ddr_wr_be(ddr_wr_be), .ddr_wr_valid(ddr_wr_valid),
        .ddr_wr_last(ddr_wr_last), .ddr_wr_ready(ddr_wr_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  be;
    } word_t;

    typedef struct {
        int          npix;
        int          n_bursts;
        logic [4:0]  last_len;
        logic [31:0] last_be;
    } vec_t;

    int           n_chk = 0, n_fail = 0;
    logic [31:0]  line_q[$];
    word_t        exp_q[$];
    logic [4:0]   lens_q[$];
    word_t        w;
    logic [27:0]  exp_addr = '0;
    logic [4:0]   cur_len = '0;
    int           beat_idx = 0, n_last = 0, n_req = 0, ack_dly = 0;
    logic         ack_en = 0, rand_ready = 0, strict8 = 0;
    logic [255:0] first_beat = '0;
    logic [31:0]  last_be = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: a word is whatever pixels were collected when 8 arrived or a line ended
    function automatic void model_pix(input logic [31:0] d, input logic last);
        word_t nw;
        line_q.push_back(d);
        if (line_q.size() == 8 || last) begin
            nw.d = '0;
            nw.be = '0;
            foreach (line_q[k]) begin
                nw.d[k*32 +: 32] = line_q[k];
                nw.be[k*4 +: 4] = 4'hF;
            end
            exp_q.push_back(nw);
            line_q.delete();
        end
    endfunction

    task automatic send_pix(input logic [31:0] d, input logic last);
        int t = 0;
        logic ok;
        pix_data = d;
        pix_last = last;
        pix_valid = 1;
        @(negedge clk);
        while (!pix_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = pix_ready;
        if (!ok) chk("pix_accept_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
        pix_valid = 0;
        pix_last = 0;
        if (ok) model_pix(d, last);
    endtask

    task automatic send_line(input int n, input logic last_at_end, input int seed);
        for (int i = 0; i < n; i++) send_pix(32'(seed + i), last_at_end && (i == n - 1));
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_words_left", 256'(exp_q.size()), 256'(0));
        chk("busy_after_drain", 256'(busy), 256'(0));
    endtask

    task automatic do_frame(input logic [27:0] base, input logic honour);
        frame_start = 1;
        frame_base = base;
        @(negedge clk);
        chk("pix_ready_in_frame_start", 256'(pix_ready), 256'(0));
        @(posedge clk);
        #1;
        frame_start = 0;
        if (honour) exp_addr = base;
    endtask

    task automatic do_reset();
        rst_n = 0;
        line_q.delete();
        exp_q.delete();
        beat_idx = 0;
        exp_addr = '0;
        @(negedge clk);
        chk("rst_burst_req", 256'(burst_req), 256'(0));
        chk("rst_burst_addr", 256'(burst_addr), 256'(0));
        chk("rst_burst_len", 256'(burst_len), 256'(0));
        chk("rst_wr_valid", 256'(ddr_wr_valid), 256'(0));
        chk("rst_wr_last", 256'(ddr_wr_last), 256'(0));
        chk("rst_wr_data", ddr_wr_data, 256'(0));
        chk("rst_wr_be", 256'(ddr_wr_be), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // random back-pressure on the data channel
    initial forever begin
        @(posedge clk);
        #2;
        if (rand_ready) ddr_wr_ready = 1'($urandom_range(0, 1));
    end

    // arbiter model: check each request, then acknowledge after ack_dly cycles
    initial forever begin
        @(negedge clk);
        if (rst_n && burst_req && ack_en) begin
            chk("burst_addr", 256'(burst_addr), 256'(exp_addr));
            chk("burst_len_range", 256'(burst_len >= 5'd1 && burst_len <= 5'd8), 256'(1));
            if (strict8) chk("burst_len_8", 256'(burst_len), 256'(8));
            cur_len = burst_len;
            lens_q.push_back(burst_len);
            n_req++;
            repeat (ack_dly) @(posedge clk);
            #1 burst_ack = 1;
            @(posedge clk);
            #1 burst_ack = 0;
        end
    end

    // data-channel scoreboard
    always @(negedge clk) begin
        if (rst_n && ddr_wr_valid && ddr_wr_ready) begin
            if (exp_q.size() == 0) chk("spurious_beat", 256'(1), 256'(0));
            else begin
                w = exp_q.pop_front();
                chk("wr_data", ddr_wr_data, w.d);
                chk("wr_be", 256'(ddr_wr_be), 256'(w.be));
            end
            chk("wr_last", 256'(ddr_wr_last), 256'(beat_idx == int'(cur_len) - 1));
            if (beat_idx == 0) first_beat = ddr_wr_data;
            last_be = ddr_wr_be;
            if (ddr_wr_last) n_last++;
            if (beat_idx == int'(cur_len) - 1) begin
                beat_idx = 0;
                exp_addr = exp_addr + 28'(cur_len);
            end else beat_idx++;
        end
    end

    initial begin
        vec_t         vt[6];
        logic [255:0] beat0;
        logic         seen;
        int           n, stall, req0, last0;
        vt[0] = '{10, 1, 5'd2, 32'h0000_00FF};
        vt[1] = '{1,  1, 5'd1, 32'h0000_000F};
        vt[2] = '{3,  1, 5'd1, 32'h0000_0FFF};
        vt[3] = '{16, 1, 5'd2, 32'hFFFF_FFFF};
        vt[4] = '{17, 1, 5'd3, 32'h0000_000F};
        vt[5] = '{72, 2, 5'd1, 32'hFFFF_FFFF};

        @(posedge clk);
        #1;
        do_reset();

        // reset in the middle of a stalled burst
        ack_en = 1;
        ack_dly = 0;
        ddr_wr_ready = 0;
        send_line(80, 0, 5000);
        n = 0;
        while (!ddr_wr_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("valid_before_reset", 256'(ddr_wr_valid), 256'(1));
        chk("busy_before_reset", 256'(busy), 256'(1));
        do_reset();

        // one full burst from frame_base 0x100
        ack_dly = 2;
        ddr_wr_ready = 1;
        lens_q.delete();
        do_frame(28'h100, 1);
        send_line(64, 0, 0);
        wait_drain();
        beat0 = '0;
        for (int k = 0; k < 8; k++) beat0[k*32 +: 32] = 32'(k);
        chk("t2_n_bursts", 256'(lens_q.size()), 256'(1));
        if (lens_q.size() > 0) chk("t2_len", 256'(lens_q[0]), 256'(8));
        chk("t2_beat0", first_beat, beat0);
        chk("t2_next_addr", 256'(burst_addr), 256'(28'h108));

        // line-end flush lengths and partial byte enables
        for (int v = 0; v < 6; v++) begin
            lens_q.delete();
            send_line(vt[v].npix, 1, 100 * v);
            wait_drain();
            chk("vec_n_bursts", 256'(lens_q.size()), 256'(vt[v].n_bursts));
            if (lens_q.size() > 0) chk("vec_last_len", 256'(lens_q[$]), 256'(vt[v].last_len));
            chk("vec_last_be", 256'(last_be), 256'(vt[v].last_be));
        end

        // a full word with no line end must wait: the earlier flush is spent
        send_line(8, 0, 777);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen |= burst_req;
        end
        @(posedge clk);
        #1;
        chk("stale_flush", 256'(seen), 256'(0));
        send_pix(32'hABCD, 1);
        wait_drain();

        // FIFO fill under full back-pressure, then release
        ack_en = 0;
        ddr_wr_ready = 0;
        n = 0;
        stall = 0;
        pix_valid = 1;
        pix_last = 0;
        pix_data = 0;
        for (int c = 0; c < 400 && stall < 10; c++) begin
            @(negedge clk);
            if (pix_ready) begin
                model_pix(32'(n), 0);
                n++;
                stall = 0;
            end else stall++;
            @(posedge clk);
            #1;
            pix_data = 32'(n);
        end
        pix_valid = 0;
        chk("fill_pixels", 256'(n), 256'(128));
        ack_en = 1;
        ddr_wr_ready = 1;
        for (int i = n; i < 200; i++) send_pix(32'(i), i == 199);
        wait_drain();

        // random traffic with random data-channel back-pressure
        strict8 = 1;
        rand_ready = 1;
        req0 = n_req;
        last0 = n_last;
        for (int i = 0; i < 1024; i++) begin
            ack_dly = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_pix($urandom, 0);
        end
        wait_drain();
        rand_ready = 0;
        strict8 = 0;
        #1;
        ddr_wr_ready = 1;
        chk("t5_bursts", 256'(n_req - req0), 256'(16));
        chk("t5_lasts", 256'(n_last - last0), 256'(16));

        // frame_start while busy is ignored
        ack_dly = 1;
        send_line(3, 0, 9000);
        chk("busy_mid_word", 256'(busy), 256'(1));
        do_frame(28'h200, 0);
        send_line(61, 1, 9003);
        wait_drain();
        // honoured after drain, then an address wrap
        do_frame(28'h200, 1);
        send_line(64, 0, 9100);
        wait_drain();
        chk("t6_addr_after", 256'(burst_addr), 256'(28'h208));
        do_frame(28'hFFFFFFC, 1);
        send_line(64, 0, 9200);
        wait_drain();
        chk("wrap_addr", 256'(burst_addr), 256'(28'h4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
